// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one DATA/STAGES-bit slice per stage,
// registered inter-slice carry, valid/ready flow control and status flags.
module cla_pipe_adder #(
   parameter int unsigned DATA   = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DATA-1:0] in1,
   input  logic [DATA-1:0] in2,
   input  logic            carry_in,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DATA-1:0] sum,
   output logic            carry_out,
   output logic            overflow,
   output logic            zero
);
   localparam int unsigned W    = (STAGES == 0) ? DATA : DATA / STAGES;
   localparam int unsigned LAST = (STAGES == 0) ? 0 : STAGES - 1;
   localparam bit          CFG_BAD = (STAGES == 0) ? 1'b1 : ((DATA % STAGES) != 0);

   if (CFG_BAD) begin : g_cfg_check
      $error("cla_pipe_adder: DATA must be a non-zero multiple of STAGES");
   end

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [STAGES-1:0] rdy;
   logic [DATA-1:0]   a_q [STAGES];
   logic [DATA-1:0]   a_d [STAGES];
   logic [DATA-1:0]   b_q [STAGES];
   logic [DATA-1:0]   b_d [STAGES];
   logic [DATA-1:0]   s_q [STAGES];
   logic [DATA-1:0]   s_d [STAGES];
   logic              cm_q [STAGES];
   logic              cm_d [STAGES];

   logic [STAGES-1:0] src_v, src_c;
   logic [DATA-1:0]   src_a [STAGES];
   logic [DATA-1:0]   src_b [STAGES];
   logic [DATA-1:0]   src_s [STAGES];

   // A stage is ready if it or any stage downstream of it is empty, or the consumer takes.
   always_comb begin : ready_chain
      logic all_v;
      all_v = 1'b1;
      rdy   = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         all_v         = all_v & v_q[LAST - k];
         rdy[LAST - k] = out_ready | ~all_v;
      end
   end

   always_comb begin : stage_sources
      src_v[0] = in_valid;
      src_a[0] = in1;
      src_b[0] = sub ? ~in2 : in2;
      src_c[0] = sub | carry_in;
      src_s[0] = '0;
      for (int unsigned s = 1; s < STAGES; s++) begin
         src_v[s] = v_q[s-1];
         src_a[s] = a_q[s-1];
         src_b[s] = b_q[s-1];
         src_c[s] = c_q[s-1];
         src_s[s] = s_q[s-1];
      end
   end

   always_comb begin : slice_add
      logic [W-1:0]    g, p;
      logic [W:0]      cy;
      logic [DATA-1:0] s_new;
      v_d = v_q;
      c_d = c_q;
      for (int unsigned s = 0; s < STAGES; s++) begin
         a_d[s]  = a_q[s];
         b_d[s]  = b_q[s];
         s_d[s]  = s_q[s];
         cm_d[s] = cm_q[s];
      end
      for (int unsigned s = 0; s < STAGES; s++) begin
         g     = src_a[s][s*W +: W] & src_b[s][s*W +: W];
         p     = src_a[s][s*W +: W] ^ src_b[s][s*W +: W];
         cy[0] = src_c[s];
         for (int unsigned i = 0; i < W; i++) begin
            cy[i+1] = g[i] | (p[i] & cy[i]);
         end
         s_new               = src_s[s];
         s_new[s*W +: W]     = p ^ cy[W-1:0];
         if (rdy[s]) begin
            v_d[s] = src_v[s];
         end
         // Payload only moves with a real transaction, so bubbles leave stale data untouched.
         if (rdy[s] && src_v[s]) begin
            a_d[s]  = src_a[s];
            b_d[s]  = src_b[s];
            s_d[s]  = s_new;
            c_d[s]  = cy[W];
            cm_d[s] = cy[W-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         c_q <= '0;
         for (int unsigned s = 0; s < STAGES; s++) begin
            a_q[s]  <= '0;
            b_q[s]  <= '0;
            s_q[s]  <= '0;
            cm_q[s] <= 1'b0;
         end
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         for (int unsigned s = 0; s < STAGES; s++) begin
            a_q[s]  <= a_d[s];
            b_q[s]  <= b_d[s];
            s_q[s]  <= s_d[s];
            cm_q[s] <= cm_d[s];
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign carry_out = c_q[LAST];
   assign overflow  = cm_q[LAST] ^ c_q[LAST];
   // Gated by valid so an empty output stage (including after reset) reports zero=0.
   assign zero      = v_q[LAST] & ~|s_q[LAST];

endmodule
